// File: rtl/panel_clock_ctrl.sv
// Front-panel CPU clock generator: manual step, free-run and burst modes.
// Runtime divider, debounced step, glitch-free halt and a cycle counter.
module panel_clock_ctrl #(
  parameter int DIV_WIDTH       = 24,
  parameter int DEFAULT_DIV     = 13500000,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int BURST_WIDTH     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   step_btn,
  input  logic                   halt,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   cpu_clk,
  output logic                   cpu_clk_rise,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  localparam logic [DIV_WIDTH-1:0] DIV_RST =
    DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE =
    DIV_WIDTH'(1);

  localparam logic [BURST_WIDTH-1:0] BST_ONE =
    BURST_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  localparam logic [1:0] MODE_MAN  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_BST  = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

  logic [1:0]             mode_s1;
  logic [1:0]             mode_s2;
  logic                   step_s1;
  logic                   step_s2;
  logic                   halt_s1;
  logic                   halt_s2;

  logic [DB_W-1:0]        db_cnt;
  logic                   db_lvl;
  logic                   step_req;

  logic [DIV_WIDTH-1:0]   div_reg;
  logic [DIV_WIDTH-1:0]   phase_cnt;
  logic                   phase_end;

  state_t                 state_q;
  state_t                 state_d;
  logic [BURST_WIDTH-1:0] rem_q;
  logic [BURST_WIDTH-1:0] rem_d;

  logic                   is_man;
  logic                   is_auto;
  logic                   is_bst;
  logic                   halting;
  logic                   enter_high;

  // Two-flop synchronisers for the asynchronous panel inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= 2'b00;
      mode_s2 <= 2'b00;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      halt_s1 <= 1'b0;
      halt_s2 <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      step_s1 <= step_btn;
      step_s2 <= step_s1;
      halt_s1 <= halt;
      halt_s2 <= halt_s1;
    end
  end

  // Debounce: level flips only after a run of disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (step_s2 != db_lvl) begin
        if (db_cnt == DB_LAST) begin
          db_cnt   <= '0;
          db_lvl   <= step_s2;
          step_req <= step_s2;
        end else begin
          db_cnt <= db_cnt + DB_ONE;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Half-period register; a zero load would stall the phase, so drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DIV_RST;
    end else if (div_load && (div_value != '0)) begin
      div_reg <= div_value;
    end
  end

  assign is_man  = (mode_s2 == MODE_MAN);
  assign is_auto = (mode_s2 == MODE_AUTO);
  assign is_bst  = (mode_s2 == MODE_BST);
  assign halting = halt_s2 | (mode_s2 == MODE_HALT);

  assign phase_end = (phase_cnt >= (div_reg - DIV_ONE));

  assign enter_high = (state_d == HIGH) &&
                      (state_q != HIGH);

  // Next state: mode and halt are only honoured in IDLE or at end of LOW.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (!halting) begin
          unique case (1'b1)
            is_auto: begin
              state_d = HIGH;
              rem_d   = '0;
            end
            is_man: begin
              if (step_req) begin
                state_d = HIGH;
                rem_d   = '0;
              end
            end
            is_bst: begin
              if (step_req && (burst_len != '0)) begin
                state_d = HIGH;
                rem_d   = burst_len - BST_ONE;
              end
            end
            default: ;
          endcase
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          if (!halting && is_auto) begin
            state_d = HIGH;
          end else if (!halting && is_bst &&
                       (rem_q != '0)) begin
            state_d = HIGH;
            rem_d   = rem_q - BST_ONE;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State, burst remainder and phase counter (cleared on state entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      phase_cnt <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if ((state_d != state_q) || (state_d == IDLE)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + DIV_ONE;
      end
    end
  end

  // Registered panel outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      cycle_count  <= '0;
    end else begin
      cpu_clk      <= (state_d == HIGH);
      cpu_clk_rise <= enter_high;
      busy         <= (state_d != IDLE);
      halted       <= halting && (state_d == IDLE);
      if (enter_high) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_panel_clock_ctrl.sv
// Scoreboard bench for panel_clock_ctrl: stimulus queues expected
// rises and status snapshots, a monitor pops and compares them.
module tb_panel_clock_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt;
  logic        div_load;
  logic [23:0] div_value;
  logic [7:0]  burst_len;
  logic        cpu_clk;
  logic        cpu_clk_rise;
  logic        busy;
  logic        halted;
  logic [15:0] cycle_count;

  typedef struct {
    int cnt;
    int gap;
    int high;
  } rise_t;

  typedef struct {
    string name;
    bit    tmo;
    bit    c;
    bit    b;
    bit    h;
    int    cnt;
  } stat_t;

  rise_t rise_q[$];
  stat_t stat_q[$];

  int checks;
  int failures;

  panel_clock_ctrl #(
    .DIV_WIDTH      (24),
    .DEFAULT_DIV    (4),
    .DEBOUNCE_CYCLES(3),
    .BURST_WIDTH    (8),
    .CNT_WIDTH      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .step_btn    (step_btn),
    .halt        (halt),
    .div_load    (div_load),
    .div_value   (div_value),
    .burst_len   (burst_len),
    .cpu_clk     (cpu_clk),
    .cpu_clk_rise(cpu_clk_rise),
    .busy        (busy),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int    cyc_n;
    int    last_rise;
    int    hrun;
    int    pend_high;
    bit    prev_clk;
    rise_t r;
    stat_t s;
    cyc_n     = 0;
    last_rise = 0;
    hrun      = 0;
    pend_high = 0;
    prev_clk  = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        hrun      = 0;
        pend_high = 0;
        prev_clk  = 1'b0;
      end else begin
        if (cpu_clk_rise) begin
          if (rise_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rise actual=%0d required=none",
                     cycle_count);
          end else begin
            r = rise_q.pop_front();
            chk("rise.count", int'(cycle_count), r.cnt);
            chk("rise.cpu_clk", int'(cpu_clk), 1);
            if (r.gap != 0) begin
              chk("rise.period", cyc_n - last_rise, r.gap);
            end
            pend_high = r.high;
          end
          last_rise = cyc_n;
        end
        if (cpu_clk) begin
          hrun++;
        end else begin
          if (prev_clk && (pend_high != 0)) begin
            chk("high_width", hrun, pend_high);
            pend_high = 0;
          end
          hrun = 0;
        end
        prev_clk = cpu_clk;
      end
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        if (s.tmo) begin
          checks++;
          failures++;
          $display("FAIL %s actual=timeout required=event",
                   s.name);
        end else begin
          chk({s.name, ".cpu_clk"}, int'(cpu_clk), int'(s.c));
          chk({s.name, ".busy"}, int'(busy), int'(s.b));
          chk({s.name, ".halted"}, int'(halted), int'(s.h));
          chk({s.name, ".count"}, int'(cycle_count), s.cnt);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tmo(string nm);
    stat_t e;
    e.name = nm;
    e.tmo  = 1'b1;
    e.c    = 1'b0;
    e.b    = 1'b0;
    e.h    = 1'b0;
    e.cnt  = 0;
    stat_q.push_back(e);
  endtask

  task automatic exp_stat(string nm, bit c, bit b,
                          bit h, int cnt);
    stat_t e;
    e.name = nm;
    e.tmo  = 1'b0;
    e.c    = c;
    e.b    = b;
    e.h    = h;
    e.cnt  = cnt;
    stat_q.push_back(e);
  endtask

  task automatic exp_rise(int cnt, int gap, int high);
    rise_t e;
    e.cnt  = cnt;
    e.gap  = gap;
    e.high = high;
    rise_q.push_back(e);
  endtask

  task automatic wait_drain(string nm);
    int n;
    n = 0;
    while ((rise_q.size() != 0) && (n < 200)) begin
      cyc(1);
      n++;
    end
    if (rise_q.size() != 0) begin
      tmo(nm);
      rise_q.delete();
    end
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while (busy && (n < 200)) begin
      cyc(1);
      n++;
    end
    if (busy) tmo(nm);
  endtask

  task automatic wait_rise(string nm);
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!cpu_clk_rise && (n < 100));
    if (!cpu_clk_rise) tmo(nm);
  endtask

  task automatic load_div(int v);
    div_value = 24'(v);
    div_load  = 1'b1;
    cyc(1);
    div_load  = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    mode      = 2'b00;
    step_btn  = 1'b0;
    halt      = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    burst_len = '0;

    cyc(3);
    exp_stat("reset", 1'b0, 1'b0, 1'b0, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Auto: period 8, high 4.
    exp_rise(1, 0, 4);
    exp_rise(2, 8, 4);
    exp_rise(3, 8, 4);
    mode = 2'b01;
    wait_drain("auto_rises");
    mode = 2'b00;
    wait_idle("auto_idle");
    exp_stat("auto_end", 1'b0, 1'b0, 1'b0, 3);
    cyc(10);

    // Manual single step.
    exp_rise(4, 0, 4);
    step_btn = 1'b1;
    wait_rise("man_rise");
    exp_stat("man_high", 1'b1, 1'b1, 1'b0, 4);
    cyc(4);
    step_btn = 1'b0;
    cyc(3);
    exp_stat("man_low", 1'b0, 1'b1, 1'b0, 4);
    cyc(1);
    exp_stat("man_done", 1'b0, 1'b0, 1'b0, 4);
    cyc(20);

    // Two-clk glitch must not step.
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    cyc(20);
    exp_stat("glitch", 1'b0, 1'b0, 1'b0, 4);
    cyc(2);

    // Burst of five.
    mode      = 2'b10;
    burst_len = 8'd5;
    cyc(4);
    exp_rise(5, 0, 4);
    exp_rise(6, 8, 4);
    exp_rise(7, 8, 4);
    exp_rise(8, 8, 4);
    exp_rise(9, 8, 4);
    step_btn = 1'b1;
    cyc(10);
    step_btn = 1'b0;
    wait_drain("burst_rises");
    wait_idle("burst_idle");
    exp_stat("burst_end", 1'b0, 1'b0, 1'b0, 9);
    cyc(20);

    // Zero-length burst is ignored.
    burst_len = 8'd0;
    step_btn  = 1'b1;
    cyc(10);
    step_btn  = 1'b0;
    cyc(20);
    exp_stat("burst_zero", 1'b0, 1'b0, 1'b0, 9);
    cyc(2);

    // Halt one clk into HIGH: full high and low, then IDLE.
    exp_rise(10, 0, 4);
    mode = 2'b01;
    wait_rise("halt_rise");
    halt = 1'b1;
    cyc(7);
    exp_stat("halt_low", 1'b0, 1'b1, 1'b0, 10);
    cyc(1);
    exp_stat("halt_idle", 1'b0, 1'b0, 1'b1, 10);
    cyc(5);

    // Divider 2 while halted, resume: period 4.
    load_div(2);
    exp_rise(11, 0, 2);
    exp_rise(12, 4, 2);
    exp_rise(13, 4, 2);
    halt = 1'b0;
    wait_drain("div2_rises");
    halt = 1'b1;
    wait_idle("div2_idle");
    exp_stat("div2_halted", 1'b0, 1'b0, 1'b1, 13);
    cyc(3);

    // Zero divider load is ignored.
    load_div(0);
    exp_rise(14, 0, 2);
    exp_rise(15, 4, 2);
    halt = 1'b0;
    wait_drain("div0_rises");
    halt = 1'b1;
    wait_idle("div0_idle");
    exp_stat("div0_halted", 1'b0, 1'b0, 1'b1, 15);
    mode = 2'b00;
    halt = 1'b0;
    cyc(10);
    exp_stat("unhalted", 1'b0, 1'b0, 1'b0, 15);
    cyc(2);

    // Reset in the middle of a HIGH phase.
    exp_rise(16, 0, 0);
    mode = 2'b01;
    wait_drain("pre_reset_rise");
    rst_n = 1'b0;
    exp_stat("mid_reset", 1'b0, 1'b0, 1'b0, 0);
    cyc(3);
    exp_rise(1, 0, 4);
    exp_rise(2, 8, 4);
    rst_n = 1'b1;
    wait_drain("post_reset_rises");
    mode = 2'b00;
    wait_idle("post_reset_idle");
    exp_stat("final", 1'b0, 1'b0, 1'b0, 2);
    cyc(3);

    if (rise_q.size() != 0) tmo("leftover_rises");
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
